parity: RTL and testbench
=========================

Name: parity

Overview:
- Parity-bit generator for the UART transmitter data path.
- Takes the parallel TX data byte and a 2-bit parity mode, and produces one registered parity bit.
- The frame serializer inserts this bit between the last data bit and the stop bit.
- Purely combinational reduction feeding a single output register; no handshake.

Parameters:
- DATA_WIDTH, 8, width of data_in in bits; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = reset asserted, 1 = normal operation.
- data_in  input  DATA_WIDTH  data word whose parity is computed.
- parity_type  input  2  parity mode select; encoding below.
- parity_out  output  1  registered parity bit.

Behaviour:
- Mode encoding:
  - 2'b00 = no parity.
  - 2'b01 = odd parity.
  - 2'b10 = even parity.
  - 2'b11 = no parity (reserved; treated exactly like 2'b00).
- Odd: parity_out = XNOR-reduction of data_in, so ones(data_in) + parity_out is odd.
- Even: parity_out = XOR-reduction of data_in, so ones(data_in) + parity_out is even.
- No-parity modes: parity_out = 1 (line-idle level, harmless if the framer ignores it).
- Latency:
  - data_in and parity_type are sampled on each rising clk edge.
  - parity_out reflects them one cycle later and holds until the next edge.
  - No enable input: the register updates every cycle.
- Reset:
  - rst = 0 forces parity_out to 0 immediately, independent of clk.
  - While rst = 0, data_in and parity_type are ignored.
  - Reset mid-operation discards the pending result.
- Reset release: on the first rising edge with rst = 1, the register loads the value computed from the current inputs.
- Mode change: takes effect on the next edge; no other state exists, so there is no glitch filtering or history.
- Boundary values:
  - data_in all-zero: odd -> 1, even -> 0.
  - data_in all-ones (DATA_WIDTH = 8): odd -> 1, even -> 0.
- X/unknown inputs are not specially handled.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- When defined, the block adds a receive-side checker with these extra ports:
  - rx_parity_bit  input  1: parity bit received with the data.
  - parity_err  output  1: registered mismatch flag.
- parity_err behaviour:
  - Set to 1 on the clock edge when the mode is odd or even and rx_parity_bit differs from the value computed from the same-cycle data_in.
  - 0 in the no-parity modes.
  - Reset value 0; same latency as parity_out.
- When not defined, the extra ports and logic are absent and the interface is exactly the ports listed above.

Decomposition:
- Shared package uart_pkg:
  - Localparams PAR_NONE = 2'b00, PAR_ODD = 2'b01, PAR_EVEN = 2'b10, PAR_RSVD = 2'b11.
  - Default DATA_WIDTH constant.
- One natural sub-module: xor_reduce, a parameterized balanced XOR tree returning the even-parity bit of a DATA_WIDTH vector.
- The top level inverts that bit for odd mode, muxes the constant 1 for no-parity modes, and registers the result.

Test Plan:
- Reset: hold rst = 0 with data_in = 8'hE0, parity_type = 01, clk running -> parity_out = 0 throughout. Release rst -> next edge parity_out = 0.
- Mode sweep, data_in = 8'b11100000 (3 ones):
  - 01 -> 0.
  - 10 -> 1.
  - 00 -> 1.
  - 11 -> 1.
  - Each result appears one cycle after the input is applied.
- Even/odd pairs:
  - 8'b01010101: 10 -> 0, 01 -> 1.
  - 8'b00001111: 01 -> 1.
  - 8'b10110000: 10 -> 1.
- Extremes:
  - 8'h00: 01 -> 1, 10 -> 0.
  - 8'hFF: 01 -> 1, 10 -> 0.
- Async reset mid-stream:
  - Setup: parity_out = 1 with data_in = 8'h0F, parity_type = 01.
  - Drop rst between clock edges -> parity_out goes to 0 before the next edge.
  - Reassert rst = 1 -> parity_out returns to 1 one edge later.
- With PARITY_CHECK_EN, data_in = 8'hE0, parity_type = 10:
  - rx_parity_bit = 1 -> parity_err = 0.
  - rx_parity_bit = 0 -> parity_err = 1.
  - parity_type = 00 -> parity_err = 0 for either rx_parity_bit value.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART data-path definitions: parity mode encodings and default data width.
package uart_pkg;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;

  localparam int DATA_WIDTH_DEF = 8;
endpackage

// File: rtl/parity_xor_reduce.sv
// Purpose: balanced XOR tree giving the even-parity bit of a DATA_WIDTH vector.
// Latency: combinational, log2(DATA_WIDTH) gate levels.
// Backpressure: none.
module xor_reduce #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  even_par
);
  localparam int LEVELS = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 0;
  localparam int PAD_W  = 1 << LEVELS;

  // Leaves are zero-padded to a power of two so every level halves cleanly.
  genvar l, k;
  for (l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [(PAD_W >> l)-1:0] v;
    if (l == 0) begin : g_leaf
      assign v = PAD_W'(data);
    end else begin : g_node
      for (k = 0; k < (PAD_W >> l); k++) begin : g_x
        assign v[k] = g_lvl[l-1].v[2*k] ^ g_lvl[l-1].v[2*k+1];
      end
    end
  end

  assign even_par = g_lvl[LEVELS].v[0];
endmodule

// File: rtl/parity.sv
// Purpose: registered UART TX parity bit (odd/even/none); PARITY_CHECK_EN adds an RX mismatch flag.
// Latency: one clk from data_in/parity_type (and rx_parity_bit) to parity_out/parity_err.
// Backpressure: none; the register updates every cycle.
module parity
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            parity_type,
  output logic                  parity_out
`ifdef PARITY_CHECK_EN
  ,
  input  logic                  rx_parity_bit,
  output logic                  parity_err
`endif
);
  logic even_par;
  logic par_nxt;
  logic par_active;

  xor_reduce #(.DATA_WIDTH(DATA_WIDTH)) u_xor_reduce (
    .data     (data_in),
    .even_par (even_par)
  );

  // No-parity modes drive the idle line level so an unused bit is harmless.
  always_comb begin
    par_nxt    = 1'b1;
    par_active = 1'b0;
    case (parity_type)
      PAR_ODD: begin
        par_nxt    = ~even_par;
        par_active = 1'b1;
      end
      PAR_EVEN: begin
        par_nxt    = even_par;
        par_active = 1'b1;
      end
      PAR_NONE, PAR_RSVD: begin
        par_nxt    = 1'b1;
        par_active = 1'b0;
      end
      default: begin
        par_nxt    = 1'b1;
        par_active = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_out <= 1'b0;
    end else begin
      parity_out <= par_nxt;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_active & (rx_parity_bit != par_nxt);
    end
  end
`else
  logic unused_active;
  assign unused_active = par_active;
`endif
endmodule

// File: tb/tb_parity.sv
// Directed bench for parity: ones-count reference model checked every cycle plus literal expectations.
module tb_parity;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [1:0]    parity_type = 2'b00;
  logic          parity_out;
`ifdef PARITY_CHECK_EN
  logic          rx_parity_bit = 1'b0;
  logic          parity_err;
`endif

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  parity #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .data_in     (data_in),
    .parity_type (parity_type),
    .parity_out  (parity_out)
`ifdef PARITY_CHECK_EN
    ,
    .rx_parity_bit (rx_parity_bit),
    .parity_err    (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference: count ones and choose the bit that makes the total odd/even.
  function automatic logic model_par(input logic [DW-1:0] d, input logic [1:0] m);
    int ones = 0;
    for (int i = 0; i < DW; i++) ones += int'(d[i]);
    if (m == 2'd1) return (ones % 2 == 0) ? 1'b1 : 1'b0;
    if (m == 2'd2) return (ones % 2 == 1) ? 1'b1 : 1'b0;
    return 1'b1;
  endfunction

  logic exp_par = 1'b0;
  logic exp_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_par <= 1'b0;
      exp_err <= 1'b0;
    end else begin
      exp_par <= model_par(data_in, parity_type);
`ifdef PARITY_CHECK_EN
      exp_err <= (parity_type == 2'd1 || parity_type == 2'd2) &&
                 (rx_parity_bit != model_par(data_in, parity_type));
`endif
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (parity_out !== (rst_n ? exp_par : 1'b0)) begin
        errors++;
        $display("FAIL model_par t=%0t got=%b exp=%b", $time, parity_out, rst_n ? exp_par : 1'b0);
      end
`ifdef PARITY_CHECK_EN
      checks++;
      if (parity_err !== (rst_n ? exp_err : 1'b0)) begin
        errors++;
        $display("FAIL model_err t=%0t got=%b exp=%b", $time, parity_err, rst_n ? exp_err : 1'b0);
      end
`endif
    end
  end

  task automatic check_lit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  // Apply inputs, let one edge sample them, then check at the following negedge.
  task automatic step(input string name, input logic [DW-1:0] d, input logic [1:0] m, input logic exp);
    data_in = d;
    parity_type = m;
    @(posedge clk);
    @(negedge clk);
    check_lit(name, parity_out, exp);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    data_in = 8'hE0;
    parity_type = 2'b01;
    @(negedge clk);
    started = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_lit("reset_hold", parity_out, 1'b0);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_lit("reset_release_e0_odd", parity_out, 1'b0);

    step("e0_odd",  8'b1110_0000, 2'b01, 1'b0);
    step("e0_even", 8'b1110_0000, 2'b10, 1'b1);
    step("e0_none", 8'b1110_0000, 2'b00, 1'b1);
    step("e0_rsvd", 8'b1110_0000, 2'b11, 1'b1);
    step("55_even", 8'b0101_0101, 2'b10, 1'b0);
    step("55_odd",  8'b0101_0101, 2'b01, 1'b1);
    step("0f_odd",  8'b0000_1111, 2'b01, 1'b1);
    step("b0_even", 8'b1011_0000, 2'b10, 1'b1);
    step("00_odd",  8'h00, 2'b01, 1'b1);
    step("00_even", 8'h00, 2'b10, 1'b0);
    step("ff_odd",  8'hFF, 2'b01, 1'b1);
    step("ff_even", 8'hFF, 2'b10, 1'b0);

    step("async_setup", 8'h0F, 2'b01, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_lit("async_drop", parity_out, 1'b0);
    @(negedge clk);
    check_lit("async_held", parity_out, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_lit("async_recover", parity_out, 1'b1);

`ifdef PARITY_CHECK_EN
    rx_parity_bit = 1'b1;
    step("chk_even_par", 8'hE0, 2'b10, 1'b1);
    check_lit("err_rx1", parity_err, 1'b0);
    rx_parity_bit = 1'b0;
    step("chk_even_par2", 8'hE0, 2'b10, 1'b1);
    check_lit("err_rx0", parity_err, 1'b1);
    rx_parity_bit = 1'b0;
    step("chk_none_rx0", 8'hE0, 2'b00, 1'b1);
    check_lit("err_none_rx0", parity_err, 1'b0);
    rx_parity_bit = 1'b1;
    step("chk_none_rx1", 8'hE0, 2'b00, 1'b1);
    check_lit("err_none_rx1", parity_err, 1'b0);
`endif

    // Random tail exercised only by the per-cycle model comparison.
    for (int i = 0; i < 40; i++) begin
      data_in = DW'($urandom);
      parity_type = 2'($urandom_range(0, 3));
`ifdef PARITY_CHECK_EN
      rx_parity_bit = 1'($urandom_range(0, 1));
`endif
      @(negedge clk);
    end

    started = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
